byte_memory_ctrl: RTL and testbench

Parametrised, byte-addressed, little-endian memory with a request/done handshake. It supports byte, half and word accesses, sign or zero extension on loads, and misaligned accesses split into two word beats. It also detects out-of-range accesses. It replaces the fixed 1 KiB word-only store as the common instruction/data memory of the multi-cycle CPU.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/byte_memory_ctrl.sv | 161 ++++++++++++++++
 tb/tb_byte_memory_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared size codes, FSM state type and access-width helper for byte_memory_ctrl.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } mem_state_t;

  // The illegal code 11 maps to 4 so that lane maths stays bounded; it never accesses memory.
  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and shifted write word per beat,
// plus the rotated, merged and extended load value.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_beat,
  input  logic        i_sext,
  input  logic [31:0] i_raw,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_split
);

  logic [3:0]  w_bm;
  logic [7:0]  w_bm8;
  logic [63:0] w_w64;
  logic [63:0] w_r64;
  logic [31:0] w_val;
  logic [5:0]  w_shamt;

  assign w_shamt = {i_off, 3'b000};
  assign o_split = ({1'b0, i_off} + nbytes(i_size)) > 3'd4;

  always_comb begin
    w_bm = 4'b1111;
    case (i_size)
      SIZE_B:  w_bm = 4'b0001;
      SIZE_H:  w_bm = 4'b0011;
      default: w_bm = 4'b1111;
    endcase
    w_bm8   = {4'b0000, w_bm} << i_off;
    o_be    = i_beat ? w_bm8[7:4] : w_bm8[3:0];

    // Treat the two beats as one 64-bit window: beat 0 is the low word, beat 1 the high word.
    w_w64   = {32'h0, i_wdata} << w_shamt;
    o_wword = i_beat ? 32'(w_w64 >> 32) : 32'(w_w64);

    w_r64   = i_beat ? {i_raw, i_lo} : {32'h0, i_raw};
    w_val   = 32'(w_r64 >> w_shamt);

    o_rdata = w_val;
    case (i_size)
      SIZE_B:  o_rdata = {{24{i_sext & w_val[7]}}, w_val[7:0]};
      SIZE_H:  o_rdata = {{16{i_sext & w_val[15]}}, w_val[15:0]};
      default: o_rdata = w_val;
    endcase
  end

endmodule

// File: rtl/byte_memory_ctrl.sv
// Byte-addressed little-endian memory with req/done handshake, sub-word access,
// misaligned split into two word beats, and out-of-range/illegal-size fault.
module byte_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter     INIT_FILE   = ""
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic              Ready,
  output logic              Done,
  output logic [31:0]       DataOut,
  output logic              Fault
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int WA_W        = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

  logic [31:0] r_mem [DEPTH_WORDS];

  mem_state_t      r_state;
  mem_state_t      w_next;
  logic [1:0]      r_off;
  logic [WA_W-1:0] r_widx;
  logic            r_rw;
  logic [1:0]      r_size;
  logic            r_sext;
  logic [31:0]     r_wdata;
  logic            r_fault;
  logic [31:0]     r_lo;
  logic            r_done;
  logic            r_dfault;
  logic [31:0]     r_dout;

  logic            w_accept;
  logic            w_mem_we;
  logic            w_finish;
  logic            w_beat;
  logic [WA_W-1:0] w_widx;
  logic [31:0]     w_raw;
  logic [3:0]      w_be;
  logic [31:0]     w_wword;
  logic [31:0]     w_rdata;
  logic            w_split;
  logic [ADDR_W:0] w_end;
  logic            w_req_fault;

  // Widened by one bit so an access running past the top cannot wrap to a legal address.
  assign w_end       = {1'b0, Addr} + (ADDR_W+1)'(nbytes(Size));
  assign w_req_fault = (Size == 2'b11) || (w_end > DEPTH_L);

  assign w_beat = (r_state == BEAT1);
  assign w_widx = r_widx + WA_W'(w_beat);
  assign w_raw  = r_mem[w_widx];

  mem_lane_align u_align (
    .i_off   (r_off),
    .i_size  (r_size),
    .i_beat  (w_beat),
    .i_sext  (r_sext),
    .i_raw   (w_raw),
    .i_lo    (r_lo),
    .i_wdata (r_wdata),
    .o_be    (w_be),
    .o_wword (w_wword),
    .o_rdata (w_rdata),
    .o_split (w_split)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    Ready    = 1'b0;
    w_accept = 1'b0;
    w_mem_we = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        Ready = 1'b1;
        if (Req) begin
          w_accept = 1'b1;
          w_next   = BEAT0;
        end
      end
      BEAT0: begin
        if (r_fault) begin
          w_next   = IDLE;
          w_finish = 1'b1;
        end else begin
          w_mem_we = r_rw;
          if (w_split) begin
            w_next = BEAT1;
          end else begin
            w_next   = IDLE;
            w_finish = 1'b1;
          end
        end
      end
      BEAT1: begin
        w_mem_we = r_rw;
        w_next   = IDLE;
        w_finish = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_off    <= '0;
      r_widx   <= '0;
      r_rw     <= 1'b0;
      r_size   <= '0;
      r_sext   <= 1'b0;
      r_wdata  <= '0;
      r_fault  <= 1'b0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dfault <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_done   <= w_finish;
      r_dfault <= w_finish & r_fault;
      if (w_accept) begin
        r_off   <= Addr[1:0];
        r_widx  <= Addr[WA_W+1:2];
        r_rw    <= RW;
        r_size  <= Size;
        r_sext  <= SignExt;
        r_wdata <= DataIn;
        r_fault <= w_req_fault;
      end
      if (r_state == BEAT0) r_lo <= w_raw;
      if (w_finish && !r_fault && !r_rw) r_dout <= w_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_mem_we && w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wword[8*i +: 8];
    end
  end

  assign Done    = r_done;
  assign Fault   = r_dfault;
  assign DataOut = r_dout;

endmodule

// File: tb/tb_byte_memory_ctrl.sv
// Directed self-checking bench for byte_memory_ctrl with hand-computed expectations.
module tb_byte_memory_ctrl;

  logic        CLK;
  logic        RST;
  logic        Req;
  logic        RW;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        Ready;
  logic        Done;
  logic [31:0] DataOut;
  logic        Fault;

  int          n_cmp;
  int          n_bad;
  int          lat;
  int          n_done;
  logic        got_fault;
  logic [31:0] got_dout;

  byte_memory_ctrl #(
    .ADDR_W      (32),
    .DEPTH_BYTES (1024),
    .INIT_FILE   ("")
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Req     (Req),
    .RW      (RW),
    .Size    (Size),
    .SignExt (SignExt),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .Ready   (Ready),
    .Done    (Done),
    .DataOut (DataOut),
    .Fault   (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request from an IDLE cycle and waits (bounded) for Done.
  task automatic xact(input string tag, input logic rw, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a, input logic [31:0] d);
    Req = 1'b1; RW = rw; Size = sz; SignExt = sx; Addr = a; DataIn = d;
    @(posedge CLK); #1;
    Req = 1'b0;
    lat = 0;
    while (!Done && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    got_fault = Fault;
    got_dout  = DataOut;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_done = 0;
    RST = 1'b0; Req = 1'b0; RW = 1'b0; Size = 2'b00; SignExt = 1'b0;
    Addr = '0; DataIn = '0;

    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    chk("rst_dout", DataOut, 32'h0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Clear the words the misaligned test inspects.
    xact("clr0c", 1'b1, 2'b10, 1'b0, 32'h0C, 32'h0);
    xact("clr10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);

    xact("mis_wr", 1'b1, 2'b10, 1'b0, 32'h0E, 32'hDEADBEEF);
    chk("mis_wr_lat", lat, 32'd2);
    chk("mis_wr_fault", 32'(got_fault), 32'd0);
    chk("mis_wr_dout", got_dout, 32'h0);
    xact("rd0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    chk("rd0c_val", got_dout, 32'hBEEF0000);
    xact("rd10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("rd10_val", got_dout, 32'h0000DEAD);
    xact("rdh0f", 1'b0, 2'b01, 1'b1, 32'h0F, 32'h0);
    chk("rdh0f_lat", lat, 32'd2);
    chk("rdh0f_val", got_dout, 32'hFFFFADBE);

    xact("wr10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    chk("wr10_lat", lat, 32'd1);
    xact("rd10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("rd10b_lat", lat, 32'd1);
    chk("rd10b_fault", 32'(got_fault), 32'd0);
    chk("rd10b_val", got_dout, 32'h11223344);
    xact("rdb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("rdb13_val", got_dout, 32'h00000011);

    xact("wr20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD);
    xact("wrb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h123456F0);
    xact("rdb21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    chk("rdb21_val", got_dout, 32'hFFFFFFF0);
    xact("rd20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rd20_val", got_dout, 32'hAABBF0DD);

    // Top-of-memory boundary: last half is legal, a word at 1022 is not.
    xact("wr3fc", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h55667788);
    xact("rdh3fe", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0);
    chk("rdh3fe_fault", 32'(got_fault), 32'd0);
    chk("rdh3fe_val", got_dout, 32'h00005566);
    xact("rdw3fe", 1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0);
    chk("rdw3fe_lat", lat, 32'd1);
    chk("rdw3fe_fault", 32'(got_fault), 32'd1);
    chk("rdw3fe_held", got_dout, 32'h00005566);
    xact("wrw3fe", 1'b1, 2'b10, 1'b0, 32'h3FE, 32'hFFFFFFFF);
    chk("wrw3fe_fault", 32'(got_fault), 32'd1);
    xact("rd3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    chk("rd3fc_val", got_dout, 32'h55667788);
    xact("sz11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    chk("sz11_lat", lat, 32'd1);
    chk("sz11_fault", 32'(got_fault), 32'd1);
    chk("sz11_held", got_dout, 32'h55667788);

    // Req held high: acceptances on alternate edges, Done on the others.
    Req = 1'b1; RW = 1'b0; Size = 2'b10; SignExt = 1'b0; Addr = 32'h10; DataIn = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      chk("b2b_done", 32'(Done), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (Done) begin
        n_done++;
        chk("b2b_val", DataOut, 32'h11223344);
      end
    end
    Req = 1'b0;
    chk("b2b_count", n_done, 32'd4);

    // Request while busy must be dropped.
    Req = 1'b1; RW = 1'b0; Size = 2'b10; Addr = 32'h20;
    @(posedge CLK); #1;
    chk("busy_ready", 32'(Ready), 32'd0);
    RW = 1'b1; DataIn = 32'h0;
    @(posedge CLK); #1;
    chk("busy_done", 32'(Done), 32'd1);
    Req = 1'b0;
    @(posedge CLK); #1;
    chk("busy_idle", 32'(Ready), 32'd1);
    chk("busy_nodone", 32'(Done), 32'd0);
    xact("rd20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rd20b_val", got_dout, 32'hAABBF0DD);

    // Reset during BEAT1 of a split write: first half stays, second half dropped.
    xact("clr40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    xact("clr44", 1'b1, 2'b10, 1'b0, 32'h44, 32'h0);
    Req = 1'b1; RW = 1'b1; Size = 2'b10; Addr = 32'h42; DataIn = 32'h99887766;
    @(posedge CLK); #1;
    Req = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("rstmid_ready", 32'(Ready), 32'd1);
    chk("rstmid_done", 32'(Done), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rstmid_nodone", 32'(Done), 32'd0);
    xact("rd40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("rd40_val", got_dout, 32'h77660000);
    xact("rd44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    chk("rd44_val", got_dout, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
